bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter that shares the 8-bit system data bus between up to `NUM_REQ` drivers (memory read port, ALU result, register file, I/O). It sits between the requesters and the bus: it grants exactly one owner at a time and multiplexes that owner's data onto `bus`. A watchdog revokes stuck grants. One mandatory idle cycle separates owners to prevent drive overlap.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `DATA_WIDTH`, default 8: bus width.
- `TIMEOUT`, default 15: maximum number of consecutive BUSY cycles per grant, range 1..255.

Ports:
- `clock` in 1: system clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `req` in NUM_REQ: request per requester; level, held until granted.
- `done` in NUM_REQ: release pulse from the current owner; ignored from non-owners.
- `data_in` in NUM_REQ*DATA_WIDTH: flat per-requester drive data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `err_clear` in 1: clears `timeout_err`.
- `grant` out NUM_REQ: one-hot or zero; registered.
- `owner` out $clog2(NUM_REQ): index of the current owner; 0 when not BUSY.
- `bus_busy` out 1: high exactly in BUSY.
- `bus` out DATA_WIDTH: `data_in` slice of the owner in BUSY, else all zeros; combinational from registered state.
- `timeout_err` out 1: sticky watchdog flag.
- `err_owner` out $clog2(NUM_REQ): owner revoked by the last timeout.

## Operation
- States: ARB_IDLE, ARB_BUSY, ARB_TURN. Reset state is ARB_IDLE.
- Reset (asynchronous, while `reset`=0):
  - `grant`=0, `owner`=0, `bus_busy`=0, `bus`=0, `timeout_err`=0, `err_owner`=0.
  - Round-robin pointer=0, watchdog counter=0.
- IDLE or TURN, any `req` high: select the first asserted requester scanning from the pointer upward, wrapping modulo NUM_REQ.
  - Go to BUSY and set `grant`/`owner` to the winner.
  - Pointer becomes (winner+1) mod NUM_REQ.
  - Counter becomes 0.
- IDLE or TURN, no `req`: go to IDLE.
- BUSY, release: owner's `done`=1, or owner's `req`=0. Go to TURN and clear `grant`.
- BUSY, no release: counter increments.
  - When the counter reaches TIMEOUT-1 without release, go to TURN.
  - Set `timeout_err` and set `err_owner`=owner.
- Simultaneous events:
  - `done` and timeout in the same cycle: `done` wins and no error is raised.
  - `err_clear` and a new timeout in the same cycle: the set wins.
- Requests from non-owners during BUSY are held pending. They never preempt the owner.
- Counter width is 8 bits and never wraps, because of the TIMEOUT range.
- `timeout_err` does not block further arbitration.

## Timing
- Grant latency: `req` sampled at edge k in IDLE gives `grant` high after edge k.
- Release latency: `done` sampled at edge k gives `grant` low after edge k. The next owner can be granted after edge k+1, so there is exactly one grant-free cycle.
- The maximum grant length is TIMEOUT cycles. Revocation occurs at the edge ending the TIMEOUT-th BUSY cycle.
- Back-to-back single requester: with `req` held high and `done` pulsed each grant, the pattern is grant 1 cycle minimum, then 1 TURN cycle, repeating.
- Fairness: any continuously asserted `req` is granted within (NUM_REQ-1) grants.
- Reset mid-grant: `grant` and `bus` drop asynchronously. Arbitration resumes on the first edge after deassertion, with the pointer at 0.

## Structure
- Shared `control` package holds:
  - `arb_state_e` {ARB_IDLE, ARB_BUSY, ARB_TURN}.
  - `` `ARB_NUM_REQ `` and `` `ARB_TIMEOUT `` defaults.
  - Requester index constants: REQ_MEM=0, REQ_ALU=1, REQ_REG=2, REQ_IO=3.
- Sub-module `rr_picker`: purely combinational. It takes `req` and the pointer and returns a valid flag and the winner index. It is reused by future interrupt prioritisation.
- The arbiter top contains the FSM, pointer, watchdog, error registers and the data mux.

## Test plan
- Single request: reset, then `req`=0001 and `data_in[0]`=8'hA5. Grant is 0001 after the next edge, `bus`=8'hA5, `bus_busy`=1. `done[0]` pulse gives grant 0000 and `bus`=8'h00 the next cycle.
- Round robin: `req`=1111 held, each owner pulses `done` after 2 cycles. Grants follow order 0,1,2,3,0, each separated by exactly one zero-grant cycle.
- Timeout: TIMEOUT=4, requester 2 is granted and never sends `done`. After 4 BUSY cycles grant=0, `timeout_err`=1, `err_owner`=2. `err_clear` gives `timeout_err`=0.
- Collisions:
  - `done` on the same cycle as counter=TIMEOUT-1: release occurs with `timeout_err`=0.
  - Non-owner `done[3]` during requester 1's grant: ignored.
- Reset mid-operation: assert `reset`=0 between edges during a grant to requester 1. `grant`, `bus`, `owner` and `bus_busy` go to 0 immediately. After release, `req`=1010 grants requester 1 first, because the pointer is 0.

Source files
------------

// File: rtl/control.sv
// rtl/control.sv - shared arbitration types, defaults and requester indices
//
// Contents:
//   arb_state_e      : bus arbiter FSM states
//   ARB_NUM_REQ_DEF  : default requester count (from `ARB_NUM_REQ)
//   ARB_TIMEOUT_DEF  : default watchdog limit in BUSY cycles (from `ARB_TIMEOUT)
//   REQ_*            : fixed requester slot assignments on the system bus

`ifndef ARB_NUM_REQ
`define ARB_NUM_REQ 4
`endif

`ifndef ARB_TIMEOUT
`define ARB_TIMEOUT 15
`endif

package control;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_TURN = 2'd2
  } arb_state_e;

  localparam int ARB_NUM_REQ_DEF = `ARB_NUM_REQ;
  localparam int ARB_TIMEOUT_DEF = `ARB_TIMEOUT;

  localparam int REQ_MEM = 0;
  localparam int REQ_ALU = 1;
  localparam int REQ_REG = 2;
  localparam int REQ_IO  = 3;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
//
// Ports:
//   req    in  NUM_REQ : request vector
//   ptr    in  IDX_W   : index with highest priority this round
//   valid  out 1       : at least one request asserted
//   winner out IDX_W   : first asserted request at or above ptr, wrapping

module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   winner
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rotated;
  logic [IDX_W-1:0]   first_off;
  logic [IDX_W:0]     sum;

  // Rotate so that bit 0 is the requester at ptr; the doubled copy supplies
  // the wrapped-around upper requesters.
  assign rotated = NUM_REQ'({req, req} >> ptr);
  assign valid   = |rotated;

  // Descending scan: the last hit is the nearest offset from ptr.
  always_comb begin
    first_off = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      if (rotated[off]) begin
        first_off = IDX_W'(off);
      end
    end
  end

  assign sum    = {1'b0, ptr} + {1'b0, first_off};
  assign winner = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : sum[IDX_W-1:0];

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin system bus arbiter with grant watchdog
//
// Ports:
//   clock       in  1                  : system clock, rising edge
//   reset       in  1                  : asynchronous active-low reset
//   req         in  NUM_REQ            : level requests, held until granted
//   done        in  NUM_REQ            : release pulse, honoured only from the owner
//   data_in     in  NUM_REQ*DATA_WIDTH : per-requester drive data, slice i = requester i
//   err_clear   in  1                  : clears timeout_err
//   grant       out NUM_REQ            : registered one-hot grant (or zero)
//   owner       out IDX_W              : current owner index, 0 when not BUSY
//   bus_busy    out 1                  : high while a grant is held
//   bus         out DATA_WIDTH         : owner's data while BUSY, else zero
//   timeout_err out 1                  : sticky watchdog flag
//   err_owner   out IDX_W              : owner revoked by the most recent timeout

module bus_arbiter
  import control::*;
#(
  parameter int NUM_REQ    = ARB_NUM_REQ_DEF,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = ARB_TIMEOUT_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            done,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  input  logic                          err_clear,
  output logic [NUM_REQ-1:0]            grant,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          bus_busy,
  output logic [DATA_WIDTH-1:0]         bus,
  output logic                          timeout_err,
  output logic [$clog2(NUM_REQ)-1:0]    err_owner
);

  localparam int             IDX_W      = $clog2(NUM_REQ);
  localparam logic [7:0]     LAST_CYCLE = 8'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e          state, state_n;
  logic [IDX_W-1:0]    ptr, ptr_n;
  logic [IDX_W-1:0]    owner_n, err_owner_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic [7:0]          count, count_n;
  logic                err_n;
  logic                set_err;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_winner;
  logic                release_now;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Owner gives the bus back either explicitly or by dropping its request.
  assign release_now = done[owner] | ~req[owner];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      count       <= '0;
      grant       <= '0;
      owner       <= '0;
      timeout_err <= 1'b0;
      err_owner   <= '0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      count       <= count_n;
      grant       <= grant_n;
      owner       <= owner_n;
      timeout_err <= err_n;
      err_owner   <= err_owner_n;
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    count_n     = count;
    grant_n     = grant;
    owner_n     = owner;
    err_owner_n = err_owner;
    set_err     = 1'b0;

    case (state)
      ARB_IDLE, ARB_TURN: begin
        if (pick_valid) begin
          state_n              = ARB_BUSY;
          grant_n              = '0;
          grant_n[pick_winner] = 1'b1;
          owner_n              = pick_winner;
          ptr_n                = (pick_winner == LAST_IDX) ? '0 : pick_winner + 1'b1;
          count_n              = '0;
        end else begin
          state_n = ARB_IDLE;
          grant_n = '0;
          owner_n = '0;
        end
      end
      ARB_BUSY: begin
        // Release is checked first so a done on the final allowed cycle
        // ends the grant cleanly without flagging an error.
        if (release_now) begin
          state_n = ARB_TURN;
          grant_n = '0;
          owner_n = '0;
        end else if (count == LAST_CYCLE) begin
          state_n     = ARB_TURN;
          grant_n     = '0;
          owner_n     = '0;
          set_err     = 1'b1;
          err_owner_n = owner;
        end else begin
          count_n = count + 8'd1;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        grant_n = '0;
        owner_n = '0;
      end
    endcase

    // A fresh timeout takes precedence over a simultaneous clear.
    err_n = set_err ? 1'b1 : (err_clear ? 1'b0 : timeout_err);
  end

  assign bus_busy = (state == ARB_BUSY);

  always_comb begin
    bus = '0;
    if (bus_busy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (owner == IDX_W'(i)) begin
          bus = data_in[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule
